// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
//   Philips I2S transmitter. Accepts one stereo pair at a time through a
//   valid/ready handshake, buffers it in a single holding register, and sends
//   it MSB first with the standard one-bit delay after each WS edge. This block
//   is the WS master. All flops update on the falling edge of the bit clock.
//
// Parameters:
//   WIDTH     bits per channel word (>= 4)
//
// Ports:
//   sclk      in   1      bit clock, falling-edge active
//   rst       in   1      asynchronous active-low reset
//   in_left   in   WIDTH  left sample (two's complement, sent verbatim)
//   in_right  in   WIDTH  right sample
//   in_valid  in   1      sample pair present
//   in_ready  out  1      holding register empty
//   ws        out  1      word select, 0 = left, 1 = right
//   sdata     out  1      serial data
//   underrun  out  1      one-cycle pulse when a frame starts with no data
//
// Build option:
//   I2S_TX_UNDERRUN_REPEAT_EN  defined: an underrun frame repeats the previous
//                              pair; undefined: an underrun frame is silence.
// -----------------------------------------------------------------------------
module i2s_tx #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_left,
   input  logic [WIDTH-1:0] in_right,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ws,
   output logic             sdata,
   output logic             underrun
);

   localparam int unsigned   CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   // Current channel doubles as the WS register.
   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } chan_t;

   chan_t            r_chan;
   chan_t            w_chan_next;
   logic [CW-1:0]    r_bit_cnt;
   logic [CW-1:0]    w_bit_cnt_next;
   logic             w_wrap;
   logic             w_load;

   logic             r_hold_full;
   logic             w_hold_full_next;
   logic [WIDTH-1:0] r_hold_l;
   logic [WIDTH-1:0] r_hold_r;
   logic [WIDTH-1:0] w_hold_l_next;
   logic [WIDTH-1:0] w_hold_r_next;

   logic [WIDTH-1:0] r_frame_l;
   logic [WIDTH-1:0] r_frame_r;
   logic [WIDTH-1:0] w_frame_l_next;
   logic [WIDTH-1:0] w_frame_r_next;

   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_next;
   logic             r_sdata;
   logic             w_sdata_next;
   logic             r_underrun;
   logic             w_underrun_next;
   logic             w_accept;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(negedge sclk or negedge rst) begin
      if (!rst) begin
         r_chan      <= CH_RIGHT;
         r_bit_cnt   <= LAST_BIT;
         r_hold_full <= 1'b0;
         r_hold_l    <= '0;
         r_hold_r    <= '0;
         r_frame_l   <= '0;
         r_frame_r   <= '0;
         r_shift     <= '0;
         r_sdata     <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_chan      <= w_chan_next;
         r_bit_cnt   <= w_bit_cnt_next;
         r_hold_full <= w_hold_full_next;
         r_hold_l    <= w_hold_l_next;
         r_hold_r    <= w_hold_r_next;
         r_frame_l   <= w_frame_l_next;
         r_frame_r   <= w_frame_r_next;
         r_shift     <= w_shift_next;
         r_sdata     <= w_sdata_next;
         r_underrun  <= w_underrun_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Half-frame sequencing: bit counter and channel (WS) state
   // ---------------------------------------------------------------------------
   always_comb begin
      w_chan_next    = r_chan;
      w_bit_cnt_next = r_bit_cnt + CW'(1);
      w_wrap         = (r_bit_cnt == LAST_BIT);
      w_load         = 1'b0;
      if (w_wrap) begin
         w_bit_cnt_next = '0;
         case (r_chan)
            CH_LEFT: w_chan_next = CH_RIGHT;
            CH_RIGHT: begin
               // WS falling: a new frame starts with the left word.
               w_chan_next = CH_LEFT;
               w_load      = 1'b1;
            end
            default: w_chan_next = CH_LEFT;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Holding register, frame register and serialiser
   // ---------------------------------------------------------------------------
   always_comb begin
      w_accept         = in_valid & ~r_hold_full;
      w_hold_full_next = r_hold_full;
      w_hold_l_next    = r_hold_l;
      w_hold_r_next    = r_hold_r;
      w_frame_l_next   = r_frame_l;
      w_frame_r_next   = r_frame_r;
      w_underrun_next  = 1'b0;

      if (w_load) begin
         if (r_hold_full) begin
            w_frame_l_next   = r_hold_l;
            w_frame_r_next   = r_hold_r;
            w_hold_full_next = 1'b0;
         end else if (w_accept) begin
            // Pair arriving on the load edge goes straight into the frame.
            w_frame_l_next = in_left;
            w_frame_r_next = in_right;
         end else begin
            w_underrun_next = 1'b1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            w_frame_l_next = r_frame_l;
            w_frame_r_next = r_frame_r;
`else
            w_frame_l_next = '0;
            w_frame_r_next = '0;
`endif
         end
      end else if (w_accept) begin
         w_hold_l_next    = in_left;
         w_hold_r_next    = in_right;
         w_hold_full_next = 1'b1;
      end

      // The shifter's MSB is always the next bit out. On a WS edge it still
      // holds the LSB of the finishing word (the one-bit delay), and is
      // reloaded with the word for the channel that starts.
      w_sdata_next = r_shift[WIDTH-1];
      if (w_wrap) begin
         w_shift_next = (r_chan == CH_RIGHT) ? w_frame_l_next : r_frame_r;
      end else begin
         w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
      end
   end

   assign in_ready = ~r_hold_full;
   assign ws       = (r_chan == CH_RIGHT);
   assign sdata    = r_sdata;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

   localparam int unsigned W = 16;

   // Idle sdata across a whole frame, and ws sampled after edges e+1..e+32 of a
   // frame loaded at edge e: 15 left samples, 16 right, then the next frame.
   localparam logic [31:0] WS_PATTERN = 32'h0001_FFFE;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
   localparam logic [31:0] STARVE_STREAM = 32'h7FFF_8000;
`else
   localparam logic [31:0] STARVE_STREAM = 32'h0000_0000;
`endif

   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
      logic [31:0] stream;   // bits expected on sdata, first bit in MSB
      logic        rdy_mid;  // in_ready one cycle after the load edge
   } vec_t;

   logic         sclk = 1'b0;
   logic         rst;
   logic [W-1:0] in_left;
   logic [W-1:0] in_right;
   logic         in_valid;
   logic         in_ready;
   logic         ws;
   logic         sdata;
   logic         underrun;

   always #5 sclk = ~sclk;

   i2s_tx #(.WIDTH(W)) dut (
      .sclk     (sclk),
      .rst      (rst),
      .in_left  (in_left),
      .in_right (in_right),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ws       (ws),
      .sdata    (sdata),
      .underrun (underrun)
   );

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] feed_l [8];
   logic [W-1:0] feed_r [8];
   int           feed_n   = 0;
   int           feed_idx = 0;
   int           hs_cnt   = 0;
   logic         feed_en  = 1'b0;
   logic         fire     = 1'b0;
   vec_t         vec [4];
   logic [31:0]  sd;
   logic [31:0]  wsp;
   int           urc;
   logic         rdy1;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present the next queued pair; fire records a handshake on the coming edge.
   task automatic drive();
      if (feed_en && feed_idx < feed_n) begin
         in_valid = 1'b1;
         in_left  = feed_l[feed_idx];
         in_right = feed_r[feed_idx];
      end else begin
         in_valid = 1'b0;
         in_left  = '0;
         in_right = '0;
      end
      fire = in_valid & in_ready;
   endtask

   // Advance to the rising edge after the next falling edge; outputs are stable.
   task automatic step();
      @(posedge sclk);
      if (fire) begin
         hs_cnt++;
         feed_idx++;
      end
      drive();
   endtask

   task automatic do_reset(input int n, input logic en);
      rst      = 1'b0;
      fire     = 1'b0;
      feed_idx = 0;
      hs_cnt   = 0;
      feed_n   = n;
      feed_en  = en;
      in_valid = 1'b0;
      in_left  = '0;
      in_right = '0;
      repeat (3) @(posedge sclk);
      rst = 1'b1;
      drive();
   endtask

   // Capture the 32 samples following a load edge.
   task automatic run_frame(output logic [31:0] o_sd, output logic [31:0] o_ws,
                            output int o_ur, output logic o_rdy1);
      o_sd   = '0;
      o_ws   = '0;
      o_ur   = 0;
      o_rdy1 = 1'b0;
      for (int i = 0; i < 32; i++) begin
         step();
         o_sd = {o_sd[30:0], sdata};
         o_ws = {o_ws[30:0], ws};
         if (i < 31 && underrun) o_ur++;
         if (i == 0) o_rdy1 = in_ready;
      end
   endtask

   initial begin
      vec[0] = '{16'hA5C3, 16'h3C5A, 32'hA5C3_3C5A, 1'b0};
      vec[1] = '{16'h1234, 16'hABCD, 32'h1234_ABCD, 1'b0};
      vec[2] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000, 1'b0};
      vec[3] = '{16'h8001, 16'h7FFE, 32'h8001_7FFE, 1'b1};

      rst      = 1'b0;
      in_valid = 1'b0;
      in_left  = '0;
      in_right = '0;

      // Reset state.
      #12;
      check1("rst_ws", ws, 1'b1);
      check1("rst_sdata", sdata, 1'b0);
      check1("rst_underrun", underrun, 1'b0);
      check1("rst_ready", in_ready, 1'b1);

      // Continuous stream from the table, in_valid held while pairs remain.
      for (int i = 0; i < 4; i++) begin
         feed_l[i] = vec[i].l;
         feed_r[i] = vec[i].r;
      end
      do_reset(4, 1'b1);
      step();
      for (int f = 0; f < 4; f++) begin
         check1("ld_ws", ws, 1'b0);
         check1("ld_underrun", underrun, 1'b0);
         check1("ld_ready", in_ready, 1'b1);
         check32("ld_pairs_taken", 32'(hs_cnt), 32'(f + 1));
         run_frame(sd, wsp, urc, rdy1);
         check32("stream", sd, vec[f].stream);
         check32("ws_pattern", wsp, WS_PATTERN);
         check32("mid_underrun", 32'(urc), 32'd0);
         check1("mid_ready", rdy1, vec[f].rdy_mid);
      end
      check1("end_underrun", underrun, 1'b1);
      check1("end_ws", ws, 1'b0);
      check32("end_pairs_taken", 32'(hs_cnt), 32'd4);
      step();
      check1("end_underrun_clear", underrun, 1'b0);

      // Starved from reset: silence, underrun once per frame.
      do_reset(0, 1'b0);
      step();
      check1("starve_ur0", underrun, 1'b1);
      check1("starve_ws0", ws, 1'b0);
      for (int f = 0; f < 3; f++) begin
         run_frame(sd, wsp, urc, rdy1);
         check32("starve_stream", sd, 32'h0);
         check32("starve_ws_pattern", wsp, WS_PATTERN);
         check32("starve_mid_ur", 32'(urc), 32'd0);
         check1("starve_ur", underrun, 1'b1);
      end

      // One pair, then starve: repeat or silence depending on build.
      feed_l[0] = 16'h7FFF;
      feed_r[0] = 16'h8000;
      do_reset(1, 1'b1);
      step();
      check1("one_ur0", underrun, 1'b0);
      check32("one_taken", 32'(hs_cnt), 32'd1);
      run_frame(sd, wsp, urc, rdy1);
      check32("one_stream0", sd, 32'h7FFF_8000);
      for (int f = 0; f < 2; f++) begin
         check1("one_ur", underrun, 1'b1);
         run_frame(sd, wsp, urc, rdy1);
         check32("one_stream", sd, STARVE_STREAM);
      end

      // Pair offered only on the second load edge: bypass, no underrun.
      feed_l[0] = 16'hC001;
      feed_r[0] = 16'h0FF0;
      do_reset(1, 1'b0);
      step();
      check1("byp_ur_first", underrun, 1'b1);
      repeat (30) step();
      feed_en = 1'b1;
      step();
      check1("byp_ready_before", in_ready, 1'b1);
      step();
      check1("byp_ws", ws, 1'b0);
      check1("byp_ur", underrun, 1'b0);
      check1("byp_ready", in_ready, 1'b1);
      check32("byp_taken", 32'(hs_cnt), 32'd1);
      run_frame(sd, wsp, urc, rdy1);
      check32("byp_stream", sd, 32'hC001_0FF0);
      check1("byp_ur_next", underrun, 1'b1);

      // Reset in the middle of the right word, with a pair held.
      feed_l[0] = 16'h1234;
      feed_r[0] = 16'hFFFF;
      feed_l[1] = 16'hAAAA;
      feed_r[1] = 16'h5555;
      do_reset(2, 1'b1);
      step();
      repeat (19) step();
      check1("pre_rst_ws", ws, 1'b1);
      check1("pre_rst_sdata", sdata, 1'b1);
      check1("pre_rst_ready", in_ready, 1'b0);
      #2;
      rst     = 1'b0;
      feed_en = 1'b0;
      fire    = 1'b0;
      #1;
      check1("arst_ws", ws, 1'b1);
      check1("arst_sdata", sdata, 1'b0);
      check1("arst_ready", in_ready, 1'b1);
      check1("arst_underrun", underrun, 1'b0);
      feed_l[0] = 16'h5A5A;
      feed_r[0] = 16'hF00F;
      do_reset(1, 1'b1);
      step();
      check1("post_ur", underrun, 1'b0);
      check1("post_ws", ws, 1'b0);
      run_frame(sd, wsp, urc, rdy1);
      check32("post_stream", sd, 32'h5A5A_F00F);
      check1("post_ur_next", underrun, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
